// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared state type, display constants and owner encoding for the LED scan controller
package led_scan_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam logic [7:0] DIGITS_OFF = 8'hFF;
    localparam logic [7:0] SEGS_OFF   = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    localparam logic       OWN0     = 1'b0;
    localparam logic       OWN1     = 1'b1;
    localparam logic [1:0] GNT_NONE = 2'b00;

    function automatic logic [1:0] owner_gnt(input logic own);
        return (own == OWN1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// rtl/led_scan_timer.sv - slot counter, digit index, blank/drive phase and frame-boundary strobe
module led_scan_timer
    import led_scan_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16,
    localparam int CW = $clog2(PRESCALE),
    localparam int DW = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic [CW:0]   drv_end_i,
    output logic [DW-1:0] dig_nxt_o,
    output logic          blank_nxt_o,
    output logic          lit_nxt_o,
    output logic          boundary_o,
    output logic          last_nxt_o
);

    localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dig_q, dig_d;

    // Next-cycle values are exported so the owner can register its outputs in step with the count.
    always_comb begin
        cnt_d = '0;
        dig_d = '0;
        if (run_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
            dig_d = (cnt_q == C_LAST) ? dig_q + 1'b1 : dig_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

    assign dig_nxt_o   = dig_d;
    assign blank_nxt_o = cnt_d < CW'(BLANK_CYC);
    assign lit_nxt_o   = !blank_nxt_o && ({1'b0, cnt_d} < drv_end_i);
    assign boundary_o  = run_i && (cnt_q == C_LAST) && (dig_q == D_LAST);
    assign last_nxt_o  = (cnt_d == C_LAST) && (dig_d == D_LAST);

endmodule

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - two-requester display arbiter and 8-digit scan driver; LED_SCAN_DIM_EN adds frame-sampled brightness
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
`ifdef LED_SCAN_DIM_EN
    input  logic [2:0]  bright,
`endif
    output logic [1:0]  gnt,
    output logic        frame_done,
    output logic [7:0]  LEDSEL,
    output logic [7:0]  LEDOUT
);

    localparam int CW = $clog2(PRESCALE);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [63:0]   snap_q, snap_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_q, last_d;
    logic          fd_q;
    logic [7:0]    sel_q, sel_d, out_q, out_d;

    logic          busy_d, nxt_own, own_req, oth_req, reload;
    logic [2:0]    dig_nxt;
    logic          blank_nxt, lit_nxt, boundary, last_nxt;
    logic [CW:0]   drv_end;

`ifdef LED_SCAN_DIM_EN
    localparam int DRV_STEP = (PRESCALE - BLANK_CYC) / 8;
    logic [2:0] bright_q, bright_d;

    assign drv_end = (CW+1)'(BLANK_CYC + (32'(bright_d) + 1) * DRV_STEP);

    always_comb begin
        bright_d = bright_q;
        if (reload) bright_d = bright;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bright_q <= 3'd7;
        else     bright_q <= bright_d;
    end
`else
    assign drv_end = (CW+1)'(PRESCALE);
`endif

    led_scan_timer #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (state_q != IDLE),
        .drv_end_i   (drv_end),
        .dig_nxt_o   (dig_nxt),
        .blank_nxt_o (blank_nxt),
        .lit_nxt_o   (lit_nxt),
        .boundary_o  (boundary),
        .last_nxt_o  (last_nxt)
    );

    always_comb begin
        gnt_d   = gnt_q;
        snap_d  = snap_q;
        hold_d  = hold_q;
        last_d  = last_q;
        busy_d  = (state_q != IDLE);
        nxt_own = gnt_q[1];
        own_req = gnt_q[1] ? req1 : req0;
        oth_req = gnt_q[1] ? req0 : req1;

        if (state_q == IDLE) begin
            if (req0 || req1) begin
                busy_d  = 1'b1;
                nxt_own = (req0 && req1) ? ~last_q : (req1 ? OWN1 : OWN0);
                hold_d  = HW'(1);
            end
        end else if (boundary) begin
            if (own_req && (hold_q < HW'(HOLD_FRAMES))) begin
                hold_d = hold_q + 1'b1;
            end else if (oth_req) begin
                nxt_own = ~gnt_q[1];
                hold_d  = HW'(1);
            end else if (!own_req) begin
                busy_d = 1'b0;
                last_d = gnt_q[1];
            end
        end

        // Snapshot and grant only move at a start or a frame boundary, which is what prevents tearing.
        reload = busy_d && ((state_q == IDLE) || boundary);
        if (reload) begin
            gnt_d  = owner_gnt(nxt_own);
            snap_d = (nxt_own == OWN1) ? data1 : data0;
        end else if (!busy_d) begin
            gnt_d = GNT_NONE;
        end

        state_d = !busy_d ? IDLE : (blank_nxt ? BLANK : DRIVE);
        sel_d   = DIGITS_OFF;
        out_d   = SEGS_OFF;
        if ((state_d == DRIVE) && lit_nxt) begin
            sel_d = ~(8'b1 << dig_nxt);
            out_d = snap_d[{dig_nxt, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
            snap_q  <= '1;
            hold_q  <= '0;
            last_q  <= OWN1;
            fd_q    <= 1'b0;
            sel_q   <= DIGITS_OFF;
            out_q   <= SEGS_OFF;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            snap_q  <= snap_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            fd_q    <= busy_d && last_nxt;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    assign gnt        = gnt_q;
    assign frame_done = fd_q;
    assign LEDSEL     = sel_q;
    assign LEDOUT     = out_q;

endmodule
